// File: rtl/template_matcher.sv
// template_matcher
//   Compares every 16x16 patch of an 80x80 search window against a latched
//   16x16 template using a sum of absolute differences (SAD). It reports the
//   row-major grid position (0..GRID-1 on each axis) of the smallest SAD. The
//   datapath is fully pipelined and takes one patch per cycle with no
//   back-pressure.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   start          begin a search (IDLE/DONE only); template_data latched
//   template_data  [15:0][15:0][7:0] reference patch
//   window_data    [15:0][15:0][7:0] candidate patch, valid with window_ready
//   window_ready   single-cycle patch strobe
//   window_done    producer's last-patch flag (coincides with window_ready)
//   receive        registered acknowledge, one pulse per accepted patch
//   busy           high while in RUN or DRAIN
//   result_valid   best_* final; held until next start or rst
//   best_row/col   grid position of the minimum SAD
//   best_sad       minimum SAD
//   seq_error      producer sequencing fault (early done / overrun)

// One patch row: S1 registers 16 absolute differences, S2 registers their sum.
module tm_row_lane #(
  parameter int NUM_LANES = 16,
  parameter int VEC_W     = 8,
  parameter int SUM_W     = 12
) (
  input  logic                                clk,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]     w,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]     t,
  output logic [SUM_W-1:0]                    row_sum
);
  logic [NUM_LANES-1:0][VEC_W-1:0] ad_q;
  logic [SUM_W-1:0]                sum_c;

  // S1: |w - t| per pixel; the data path is not reset, validity is tracked
  // at the top level.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      ad_q[i] <= (w[i] > t[i]) ? (w[i] - t[i]) : (t[i] - w[i]);
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_LANES; i++)
      sum_c = sum_c + SUM_W'(ad_q[i]);
  end

  // S2: row sum (16 * 255 = 4080 fits in 12 bits)
  always_ff @(posedge clk) begin
    row_sum <= sum_c;
  end
endmodule

module template_matcher #(
  parameter int GRID = 65,
  parameter int PIPE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0][15:0][7:0] template_data,
  input  logic [15:0][15:0][7:0] window_data,
  input  logic                   window_ready,
  input  logic                   window_done,
  output logic                   receive,
  output logic                   busy,
  output logic                   result_valid,
  output logic [6:0]             best_row,
  output logic [6:0]             best_col,
  output logic [15:0]            best_sad,
  output logic                   seq_error
);
  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 8;
  localparam int ROW_W     = VEC_W + $clog2(NUM_LANES);
  localparam int STAGES    = PIPE - 1;          // registered stages ahead of the best update
  localparam logic [6:0] LAST       = 7'(GRID - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(PIPE - 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [6:0] row;
    logic [6:0] col;
  } tag_t;

  state_t                               state, state_nx;
  logic [NUM_LANES-1:0][NUM_LANES-1:0][VEC_W-1:0] tmpl;
  logic [6:0]                           pos_row, pos_col;
  logic [STAGES-1:0]                    vld_pipe;   // [0]=S1 ... [STAGES-1]=S3
  tag_t [STAGES-1:0]                    tag_pipe;
  logic [NUM_LANES-1:0][ROW_W-1:0]      row_sum;
  logic [15:0]                          total_c, sad_q;
  logic [1:0]                           drain_cnt;
  logic                                 no_done;    // DRAIN entered on (LAST,LAST) without window_done
  logic                                 accept, last_tag, start_ok, finish;

  assign accept   = (state == RUN) && window_ready;
  assign last_tag = (pos_row == LAST) && (pos_col == LAST);
  assign start_ok = ((state == IDLE) || (state == DONE)) && start;
  assign finish   = accept && (window_done || last_tag);
  assign busy     = (state == RUN) || (state == DRAIN);

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (finish) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Template is pure data; only captured on an accepted start.
  always_ff @(posedge clk) begin
    if (!rst && start_ok) tmpl <= template_data;
  end

  // Per-row lanes: S1 (abs diffs) and S2 (row sums)
  for (genvar r = 0; r < NUM_LANES; r++) begin : g_lane
    tm_row_lane #(
      .NUM_LANES (NUM_LANES),
      .VEC_W     (VEC_W),
      .SUM_W     (ROW_W)
    ) u_lane (
      .clk     (clk),
      .w       (window_data[r]),
      .t       (tmpl[r]),
      .row_sum (row_sum[r])
    );
  end

  // S3: total SAD (16 * 4080 = 65280 < 2^16, no overflow)
  always_comb begin
    total_c = '0;
    for (int i = 0; i < NUM_LANES; i++)
      total_c = total_c + 16'(row_sum[i]);
  end

  always_ff @(posedge clk) begin
    sad_q <= total_c;
  end

  // Tag travels alongside the data; validity lives in vld_pipe.
  always_ff @(posedge clk) begin
    tag_pipe[0] <= '{row: pos_row, col: pos_col};
    for (int i = 1; i < STAGES; i++)
      tag_pipe[i] <= tag_pipe[i-1];
  end

  // Control, sequencing and S4 best-match update
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_row      <= '0;
      pos_col      <= '0;
      receive      <= 1'b0;
      result_valid <= 1'b0;
      seq_error    <= 1'b0;
      best_sad     <= 16'hFFFF;
      best_row     <= '0;
      best_col     <= '0;
      vld_pipe     <= '0;
      drain_cnt    <= '0;
      no_done      <= 1'b0;
    end else begin
      receive  <= accept;
      vld_pipe <= {vld_pipe[STAGES-2:0], accept};

      case (state)
        IDLE, DONE: begin
          if (start) begin
            pos_row      <= '0;
            pos_col      <= '0;
            best_sad     <= 16'hFFFF;
            best_row     <= '0;
            best_col     <= '0;
            result_valid <= 1'b0;
            seq_error    <= 1'b0;
          end
        end
        RUN: begin
          drain_cnt <= '0;
          if (accept) begin
            if (pos_col == LAST) begin
              pos_col <= '0;
              pos_row <= pos_row + 7'd1;
            end else begin
              pos_col <= pos_col + 7'd1;
            end
            if (window_done && !last_tag) seq_error <= 1'b1;
            if (finish) no_done <= !window_done;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          // A patch after (LAST,LAST) without done means the producer overran.
          if (window_ready && no_done) seq_error <= 1'b1;
          // Last in-flight patch updates best on this same edge.
          if (drain_cnt == DRAIN_LAST) result_valid <= 1'b1;
        end
        default: ;
      endcase

      // S4: strict less-than keeps the earliest patch among equal SADs.
      // The pipeline is empty whenever start is honoured, so this never
      // races the best_* clear above.
      if (vld_pipe[STAGES-1] && (sad_q < best_sad)) begin
        best_sad <= sad_q;
        best_row <= tag_pipe[STAGES-1].row;
        best_col <= tag_pipe[STAGES-1].col;
      end
    end
  end
endmodule

// File: tb/tb_template_matcher.sv
module tb_template_matcher;
  typedef logic [15:0][15:0][7:0] patch_t;
  typedef struct {
    int row;
    int col;
    int sad;
    int serr;
  } exp_t;

  localparam int M_ISO  = 0;
  localparam int M_TIE  = 1;
  localparam int M_MAX  = 2;
  localparam int M_RAND = 3;
  localparam int NPOS   = 65 * 65;

  logic        clk = 1'b0;
  logic        rst, start, window_ready, window_done;
  patch_t      template_data, window_data;
  logic        receive, busy, result_valid, seq_error;
  logic [6:0]  best_row, best_col;
  logic [15:0] best_sad;

  exp_t exp_q[$];
  int   checks  = 0;
  int   passed  = 0;
  int   rcv_cnt = 0;
  int   exp_rcv = 0;
  bit   rv_prev = 1'b0;

  always #5 clk = ~clk;

  template_matcher #(.GRID(65), .PIPE(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .template_data (template_data),
    .window_data   (window_data),
    .window_ready  (window_ready),
    .window_done   (window_done),
    .receive       (receive),
    .busy          (busy),
    .result_valid  (result_valid),
    .best_row      (best_row),
    .best_col      (best_col),
    .best_sad      (best_sad),
    .seq_error     (seq_error)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, want);
  endtask

  // Reference SAD straight from the definition.
  function automatic int sad_of(input patch_t p, input patch_t t);
    int s = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        s += (int'(p[r][c]) > int'(t[r][c])) ? int'(p[r][c]) - int'(t[r][c])
                                             : int'(t[r][c]) - int'(p[r][c]);
    return s;
  endfunction

  function automatic patch_t rand_patch(input int lo);
    patch_t p;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        p[r][c] = 8'($urandom_range(255, lo));
    return p;
  endfunction

  function automatic patch_t gen(input int mode, input int idx);
    patch_t p;
    case (mode)
      M_ISO:  p = (idx == 10 * 65 + 20) ? '0 : '1;
      M_TIE:  begin
        if (idx == 5 || idx == 3 * 65) begin
          p = '0;
          p[7][9] = 8'd100;
        end else begin
          p = rand_patch(1);
        end
      end
      M_MAX:  p = '1;
      default: p = rand_patch(0);
    endcase
    return p;
  endfunction

  // Monitor: counts receive pulses and scores each new result.
  always @(negedge clk) begin
    exp_t e;
    if (receive === 1'b1) rcv_cnt++;
    if (result_valid === 1'b1 && !rv_prev) begin
      chk("result_expected", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("best_row", 32'(best_row), 32'(e.row));
        chk("best_col", 32'(best_col), 32'(e.col));
        chk("best_sad", 32'(best_sad), 32'(e.sad));
        chk("seq_error", 32'(seq_error), 32'(e.serr));
      end
    end
    rv_prev = (result_valid === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input patch_t t);
    template_data = t;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rv_clr", 32'(result_valid), 32'd0);
    chk("start_sad_init", 32'(best_sad), 32'hFFFF);
    chk("start_serr_clr", 32'(seq_error), 32'd0);
  endtask

  task automatic send(input patch_t p, input bit done);
    window_data  = p;
    window_ready = 1'b1;
    window_done  = done;
    tick();
    window_ready = 1'b0;
    window_done  = 1'b0;
    exp_rcv++;
  endtask

  task automatic run_scan(input int mode, input int n, input bit give_done,
                          input int gap, input bit extra);
    patch_t t, p;
    exp_t   e;
    int     best, br, bc, s;
    t = (mode == M_RAND) ? rand_patch(0) : '0;
    do_start(t);
    best = 65535; br = 0; bc = 0;
    for (int i = 0; i < n; i++) begin
      p = gen(mode, i);
      s = sad_of(p, t);
      if (s < best) begin
        best = s; br = i / 65; bc = i % 65;
      end
      if (i == n - 1) begin
        e.row = br; e.col = bc; e.sad = best;
        e.serr = give_done ? int'(n != NPOS) : int'(extra);
        exp_q.push_back(e);
      end
      send(p, give_done && (i == n - 1));
      if (i != n - 1) repeat (gap) tick();
    end
    // Optional overrun patch lands in the first DRAIN cycle.
    window_ready = extra;
    tick();
    window_ready = 1'b0;
    tick();
    chk("rv_before_n4", 32'(result_valid), 32'd0);
    chk("busy_before_n4", 32'(busy), 32'd1);
    tick();
    chk("rv_at_n4", 32'(result_valid), 32'd1);
    chk("busy_at_n4", 32'(busy), 32'd0);
    repeat (2) tick();
    chk("receive_count", 32'(rcv_cnt), 32'(exp_rcv));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; window_ready = 1'b0; window_done = 1'b0;
    template_data = '0; window_data = '0;
    repeat (2) tick();
    chk("rst_receive", 32'(receive), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_serr", 32'(seq_error), 32'd0);
    chk("rst_best_sad", 32'(best_sad), 32'hFFFF);
    chk("rst_best_row", 32'(best_row), 32'd0);
    chk("rst_best_col", 32'(best_col), 32'd0);
    rst = 1'b0;

    // Patch while IDLE is ignored.
    window_ready = 1'b1;
    tick();
    window_ready = 1'b0;
    chk("idle_no_receive", 32'(receive), 32'd0);
    tick();

    run_scan(M_ISO,  NPOS, 1'b1, 1, 1'b0);   // isolated minimum at (10,20)
    run_scan(M_TIE,  NPOS, 1'b1, 0, 1'b0);   // tie: (0,5) beats (3,0)
    run_scan(M_MAX,  NPOS, 1'b1, 0, 1'b0);   // all max: (0,0), 65280
    run_scan(M_RAND, 100,  1'b1, 0, 1'b0);   // early done
    run_scan(M_RAND, NPOS, 1'b0, 0, 1'b1);   // no done, overrun in DRAIN

    // Reset mid-run, with start and a patch coinciding with rst.
    do_start('0);
    for (int i = 0; i < 500; i++) send(gen(M_ISO, i), 1'b0);
    rst = 1'b1; start = 1'b1; window_ready = 1'b1;
    tick();
    start = 1'b0; window_ready = 1'b0;
    chk("rst_mid_no_receive", 32'(receive), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_best_sad", 32'(best_sad), 32'hFFFF);
    tick();
    rst = 1'b0;
    chk("rst_start_ignored", 32'(busy), 32'd0);
    window_ready = 1'b1;
    tick();
    window_ready = 1'b0;
    chk("idle2_no_receive", 32'(receive), 32'd0);
    tick();
    chk("rst_mid_receive_count", 32'(rcv_cnt), 32'(exp_rcv));
    run_scan(M_ISO, NPOS, 1'b1, 0, 1'b0);

    repeat (4) tick();
    chk("results_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
